// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Sequences the shared multi-cycle multiply/divide unit from the execute
// stage. An R-type mul/div sitting in DX gets a one-cycle start pulse, the
// pipeline is held until the MDU answers (or a watchdog fires), and the
// result is then written through a dedicated one-cycle register-file port.
// Exceptions and timeouts write a status code to r30 instead (setx/bex
// convention).
//
// Parameters:
//   TIMEOUT   max WAIT cycles before a forced exception (2..255)
//   MUL_CODE  status written to r30 on mul exception/timeout
//   DIV_CODE  status written to r30 on div exception/timeout
//
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   dx_valid/op/aluop/rd   instruction currently held in the DX latch
//   mdu_rdy/exc/result     MDU completion pulse, exception flag, result
//   ctrl_mult, ctrl_div    one-cycle MDU start strobes
//   stall                  freeze PC/FD/DX, bubble into XM
//   dx_kill                DX instruction advances as a nop
//   wb_we/rd/data          MDU-path register-file write port
//   busy                   sequencer not idle
// ---------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned MUL_CODE = 4,
  parameter int unsigned DIV_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic [4:0]  dx_op,
  input  logic [4:0]  dx_aluop,
  input  logic [4:0]  dx_rd,
  input  logic        mdu_rdy,
  input  logic        mdu_exc,
  input  logic [31:0] mdu_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        dx_kill,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [4:0]  OP_RTYPE  = 5'b00000;
  localparam logic [4:0]  ALU_MUL   = 5'b00110;
  localparam logic [4:0]  ALU_DIV   = 5'b00111;
  localparam logic [4:0]  STATUS_RD = 5'd30;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] MUL_STAT  = 32'(MUL_CODE);
  localparam logic [31:0] DIV_STAT  = 32'(DIV_CODE);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        kind;      // 0 = mul, 1 = div
  logic [4:0]  rd_q;
  logic [31:0] res_q;
  logic        exc_q;

  logic is_mul, is_div, issue;

  assign is_mul = (dx_aluop == ALU_MUL);
  assign is_div = (dx_aluop == ALU_DIV);
  // Reset suppresses the combinational issue path so every output stays low
  // while reset is held, even with a valid mul/div parked in DX.
  assign issue  = dx_valid && (dx_op == OP_RTYPE) && (is_mul || is_div) && !reset;

  // NOTE: every output and next-state is given a default before the case so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    stall      = 1'b0;
    dx_kill    = 1'b0;
    wb_we      = 1'b0;
    wb_rd      = 5'd0;
    wb_data    = 32'd0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        if (issue) begin
          stall      = 1'b1;
          ctrl_mult  = is_mul;
          ctrl_div   = is_div;
          state_next = WAIT;
        end
      end

      WAIT: begin
        stall = 1'b1;
        busy  = 1'b1;
        // A ready pulse takes priority over the watchdog in the same cycle.
        if (mdu_rdy || (wait_cnt == WAIT_LAST)) begin
          state_next = WRITE;
        end
      end

      WRITE: begin
        // DX still holds the mul/div; killing it here prevents a reissue.
        busy       = 1'b1;
        dx_kill    = 1'b1;
        state_next = IDLE;
        if (exc_q) begin
          wb_we   = 1'b1;
          wb_rd   = STATUS_RD;
          wb_data = kind ? DIV_STAT : MUL_STAT;
        end else begin
          wb_we   = (rd_q != 5'd0);
          wb_rd   = rd_q;
          wb_data = res_q;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: every register is reset, including the result/rd holding
      // registers, so a pending MDU result can never leak into a later write.
      state    <= IDLE;
      wait_cnt <= 8'd0;
      kind     <= 1'b0;
      rd_q     <= 5'd0;
      res_q    <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (issue) begin
            kind     <= is_div;
            rd_q     <= dx_rd;
            wait_cnt <= 8'd0;
            res_q    <= 32'd0;
            exc_q    <= 1'b0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (mdu_rdy) begin
            res_q <= mdu_result;
            exc_q <= mdu_exc;
          end else if (wait_cnt == WAIT_LAST) begin
            exc_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
